ila_seq_gen: RTL

- Generates the JESD204B Initial Lane Alignment (ILA) octet stream for one lane, one octet per clk.
- Feeds the ILA input of the link mux in front of the 8b/10b encoder.
- Starts on command from the link control FSM, aligned to the LMFC.
- Emits NUM_MF multiframes: /R/ start, /A/ end, /Q/ plus 14 link-configuration octets in multiframe 1, and a ramp everywhere else.

---
 rtl/ila_seq_gen_if.sv | 34 +++
 rtl/ila_seq_gen.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ila_seq_gen_if.sv
// ila_seq_gen_if: control and data bundle between the link control FSM /
// link mux side (master) and the ILA sequence generator (slave).
//   i_start      single-cycle request to arm the ILA sequence
//   i_abort      synchronous abort back to idle
//   i_lmfc_clk   single-cycle pulse marking the first octet of a multiframe
//   i_cfg_data   link configuration octets 0..13, octet n at [8n+7:8n]
//   o_data       ILA octet
//   o_is_k       o_data is a control character
//   o_valid      o_data belongs to the ILA sequence
//   o_busy       generator armed or sending
//   o_done       pulse coincident with the final /A/
//   o_align_err  sticky LMFC misalignment flag
interface ila_seq_gen_if;
  logic         i_start;
  logic         i_abort;
  logic         i_lmfc_clk;
  logic [111:0] i_cfg_data;
  logic [7:0]   o_data;
  logic         o_is_k;
  logic         o_valid;
  logic         o_busy;
  logic         o_done;
  logic         o_align_err;

  modport master (
    output i_start, i_abort, i_lmfc_clk, i_cfg_data,
    input  o_data, o_is_k, o_valid, o_busy, o_done, o_align_err
  );

  modport slave (
    input  i_start, i_abort, i_lmfc_clk, i_cfg_data,
    output o_data, o_is_k, o_valid, o_busy, o_done, o_align_err
  );
endinterface

// File: rtl/ila_seq_gen.sv
// ila_seq_gen: JESD204B Initial Lane Alignment octet generator for one lane,
// one octet per clk. Armed by i_start, launched on an LMFC pulse, emits
// NUM_MF multiframes of F*K octets: /R/ first, /A/ last, /Q/ plus 14 link
// configuration octets in multiframe 1, an octet-index ramp elsewhere.
// Ports:
//   clk    device clock
//   rst_n  asynchronous active-low reset
//   bus    ila_seq_gen_if.slave (start/abort/lmfc/config in, octet stream out)
// Parameters: F octets/frame (1..16), K frames/multiframe (1..32),
//   17 <= F*K <= 256, NUM_MF multiframes (2..15).
module ila_seq_gen #(
  parameter int F      = 2,
  parameter int K      = 16,
  parameter int NUM_MF = 4
) (
  input logic          clk,
  input logic          rst_n,
  ila_seq_gen_if.slave bus
);

  localparam int         FK       = F * K;
  localparam logic [7:0] OCT_LAST = 8'(FK - 1);
  localparam logic [3:0] MF_LAST  = 4'(NUM_MF - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

  if (F < 1 || F > 16 || K < 1 || K > 32 || FK < 17 || FK > 256 ||
      NUM_MF < 2 || NUM_MF > 15) begin : g_param_chk
    $error("ila_seq_gen: illegal F/K/NUM_MF combination");
  end

  logic [1:0]   state, state_nx;
  logic [7:0]   oct_cnt;
  logic [3:0]   mf_cnt;
  logic [111:0] cfg_q;
  logic [7:0]   data_q;
  logic         is_k_q, valid_q, busy_q, done_q, err_q;

  logic         go;
  logic         emit;
  logic [7:0]   cur_oct;
  logic [3:0]   cur_mf;
  logic [111:0] cur_cfg;
  logic [3:0]   cfg_idx;
  logic         last;
  logic [7:0]   oct_data;
  logic         oct_k;

  // The triggering LMFC cycle itself is octet 0: /R/ is registered on the
  // launch edge and the counters resume at 1, so later LMFC pulses land
  // exactly on oct_cnt==0. go substitutes position (0,0) and the live
  // config word for that one launch cycle.
  always_comb begin
    case (state)
      ST_IDLE:  go = bus.i_start && bus.i_lmfc_clk;
      ST_ARMED: go = bus.i_lmfc_clk;
      default:  go = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    if (bus.i_abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (bus.i_start) state_nx = bus.i_lmfc_clk ? ST_SEND : ST_ARMED;
        ST_ARMED: if (bus.i_lmfc_clk) state_nx = ST_SEND;
        ST_SEND:  if (done_q) state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // SEND lingers one cycle after the final /A/ (done_q high) without
  // emitting, which keeps o_busy up one cycle longer than o_valid.
  assign emit    = !bus.i_abort && (go || (state == ST_SEND && !done_q));
  assign cur_oct = go ? 8'd0 : oct_cnt;
  assign cur_mf  = go ? 4'd0 : mf_cnt;
  assign cur_cfg = go ? bus.i_cfg_data : cfg_q;
  assign cfg_idx = 4'(cur_oct - 8'd2);
  assign last    = (cur_oct == OCT_LAST) && (cur_mf == MF_LAST);

  always_comb begin
    oct_data = cur_oct;
    oct_k    = 1'b0;
    if (cur_oct == 8'd0) begin
      oct_data = 8'h1C;
      oct_k    = 1'b1;
    end else if (cur_oct == OCT_LAST) begin
      oct_data = 8'h7C;
      oct_k    = 1'b1;
    end else if (cur_mf == 4'd1 && cur_oct == 8'd1) begin
      oct_data = 8'h9C;
      oct_k    = 1'b1;
    end else if (cur_mf == 4'd1 && cur_oct <= 8'd15) begin
      oct_data = cur_cfg[{cfg_idx, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      oct_cnt <= '0;
      mf_cnt  <= '0;
      cfg_q   <= '0;
      data_q  <= '0;
      is_k_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;

      if (emit) begin
        oct_cnt <= (cur_oct == OCT_LAST) ? 8'd0 : cur_oct + 8'd1;
        mf_cnt  <= (cur_oct == OCT_LAST) ? cur_mf + 4'd1 : cur_mf;
      end else begin
        oct_cnt <= '0;
        mf_cnt  <= '0;
      end

      if (go && !bus.i_abort) cfg_q <= bus.i_cfg_data;

      data_q  <= emit ? oct_data : 8'h00;
      is_k_q  <= emit && oct_k;
      valid_q <= emit;
      done_q  <= emit && last;
      busy_q  <= !bus.i_abort && (state_nx != ST_IDLE || state != ST_IDLE);

      if (state == ST_IDLE && bus.i_start && !bus.i_abort)
        err_q <= 1'b0;
      else if (state == ST_SEND && !done_q && !bus.i_abort &&
               bus.i_lmfc_clk && oct_cnt != 8'd0)
        err_q <= 1'b1;
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_is_k      = is_k_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_align_err = err_q;

endmodule
